// File: rtl/camera_timing_gen.sv
// OV7670-style camera source: pclk divider plus a frame FSM that produces vsync/href
// framing and a per-line byte ramp. This lets the capture path run without a sensor.
module camera_timing_gen #(
  parameter int PCLK_DIV = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int BPP      = 2,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 3,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       inclk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  output logic       pclk_o,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic [7:0] frame_cnt_o,
  output logic [2:0] state_o
);

  localparam int TLINE     = (H_ACTIVE + H_BLANK) * BPP;
  localparam int HREF_COLS = H_ACTIVE * BPP;
  localparam int DW        = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  function automatic int phase_lines(input state_t s);
    case (s)
      VSYNC:   return V_SYNC;
      VBACK:   return V_BACK;
      ACTIVE:  return V_ACTIVE;
      VFRONT:  return V_FRONT;
      default: return 0;
    endcase
  endfunction

  // First phase at or after position 'from' that has a nonzero line count;
  // IDLE means the frame is over.
  function automatic state_t first_phase(input int from);
    state_t r;
    r = IDLE;
    for (int i = 4; i >= 1; i--) begin
      if (i >= from && phase_lines(state_t'(3'(i))) > 0) r = state_t'(3'(i));
    end
    return r;
  endfunction

  logic [DW-1:0] div_q;
  logic          pclk_q;
  state_t        state_q, state_d;
  logic [15:0]   col_q, col_d;
  logic [15:0]   line_q, line_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q;
  logic [7:0]    cnt_q;
  logic          div_end, tick, frame_end;

  assign div_end = (div_q == DW'(PCLK_DIV - 1));
  // Framing advances on the pclk falling edge so receivers sampling on the rise see
  // half a pclk period of setup time.
  assign tick    = div_end && pclk_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    frame_end = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (enable_i) state_d = first_phase(1);
        end
        default: begin
          if (col_q == 16'(TLINE - 1)) begin
            col_d = '0;
            if (line_q == 16'(phase_lines(state_q) - 1)) begin
              line_d  = '0;
              state_d = first_phase(int'(state_q) + 1);
              if (state_d == IDLE) begin
                frame_end = 1'b1;
                if (enable_i) state_d = first_phase(1);
              end
            end else begin
              line_d = line_q + 16'd1;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      endcase
    end
    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == ACTIVE) && (col_d < 16'(HREF_COLS));
    data_d  = href_d ? col_d[7:0] : 8'h00;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge inclk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      if (div_end) begin
        div_q  <= '0;
        pclk_q <= ~pclk_q;
      end else begin
        div_q <= div_q + DW'(1);
      end
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= frame_end;
      cnt_q   <= cnt_q + {7'd0, frame_end};
    end
  end

  assign pclk_o       = pclk_q;
  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_camera_timing_gen.sv
// Bench for camera_timing_gen: frame-position reference model checked every inclk,
// table-driven frame runs, corner sequences, and a small second instance for wrap.
module tb_camera_timing_gen;

  localparam int PCLK_DIV = 2;
  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 2;
  localparam int BPP      = 2;
  localparam int V_SYNC   = 1;
  localparam int V_BACK   = 1;
  localparam int V_ACTIVE = 3;
  localparam int V_FRONT  = 1;
  localparam int TLINE       = (H_ACTIVE + H_BLANK) * BPP;
  localparam int FRAME_TICKS = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * TLINE;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable;
  logic       pclk_o, vsync_o, href_o, busy_o, frame_done_o;
  logic [7:0] data_o, frame_cnt_o;
  logic [2:0] state_o;

  logic       rst2, en2;
  logic       pclk2, vsync2, href2, busy2, done2;
  logic [7:0] data2, cnt2;
  logic [2:0] state2;

  camera_timing_gen #(
    .PCLK_DIV(PCLK_DIV), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .BPP(BPP),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
  ) dut (
    .inclk_i(clk), .rst_i(rst), .enable_i(enable),
    .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .data_o(data_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
    .state_o(state_o)
  );

  // Tiny frame (9 ticks, V_BACK skipped) so 256 frames fit in a short run.
  camera_timing_gen #(
    .PCLK_DIV(1), .H_ACTIVE(2), .H_BLANK(1), .BPP(1),
    .V_SYNC(1), .V_BACK(0), .V_ACTIVE(1), .V_FRONT(1)
  ) dut_wrap (
    .inclk_i(clk), .rst_i(rst2), .enable_i(en2),
    .pclk_o(pclk2), .vsync_o(vsync2), .href_o(href2), .data_o(data2),
    .busy_o(busy2), .frame_done_o(done2), .frame_cnt_o(cnt2),
    .state_o(state2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state (frame position in ticks)
  int         k;
  int         pos;
  bit         in_frame;
  logic [7:0] m_cnt;
  logic [7:0] exp_q[$];
  int         done_seen, vs_rises, vs_cyc, hr_cyc, d2;
  logic       vs_prev;

  always @(posedge clk) begin
    bit         en_s, tk, m_done, e_vs, e_hr;
    int         ln, col;
    logic [7:0] e_data;
    en_s   = enable;
    m_done = 1'b0;
    if (rst) begin
      k = 0; pos = 0; in_frame = 1'b0; m_cnt = 8'h00;
      exp_q.delete();
    end else begin
      k++;
      tk = (k % (2 * PCLK_DIV)) == 0;
      if (tk) begin
        if (!in_frame) begin
          if (en_s) begin in_frame = 1'b1; pos = 0; end
        end else begin
          pos++;
          if (pos == FRAME_TICKS) begin
            m_done = 1'b1;
            m_cnt  = m_cnt + 8'd1;
            exp_q.push_back(m_cnt);
            if (en_s) pos = 0;
            else in_frame = 1'b0;
          end
        end
      end
    end
    ln     = pos / TLINE;
    col    = pos % TLINE;
    e_vs   = in_frame && (ln < V_SYNC);
    e_hr   = in_frame && (ln >= V_SYNC + V_BACK) && (ln < V_SYNC + V_BACK + V_ACTIVE)
             && (col < H_ACTIVE * BPP);
    e_data = e_hr ? 8'(col) : 8'h00;
    #1;
    check("pclk", pclk_o, ((k / PCLK_DIV) % 2));
    check("vsync", vsync_o, e_vs);
    check("href", href_o, e_hr);
    check("data", data_o, e_data);
    check("busy", busy_o, in_frame);
    check("frame_done", frame_done_o, m_done);
    check("frame_cnt", frame_cnt_o, m_cnt);
    if (vsync_o) vs_cyc++;
    if (href_o) hr_cyc++;
    if (vsync_o && !vs_prev) vs_rises++;
    vs_prev = vsync_o;
    if (frame_done_o) begin
      done_seen++;
      check("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) check("sb_frame_cnt", frame_cnt_o, exp_q.pop_front());
    end
    if (done2) d2++;
  end

  // driver tasks
  task automatic wait_done();
    int start, b;
    start = done_seen;
    b = 0;
    while (done_seen == start && b < 2000) begin @(negedge clk); b++; end
    check("wait_done_in_budget", (b < 2000), 1);
  endtask

  task automatic wait_busy(input logic lvl);
    int b;
    b = 0;
    while (busy_o !== lvl && b < 2000) begin @(negedge clk); b++; end
    check("wait_busy_in_budget", (b < 2000), 1);
  endtask

  task automatic wait_href();
    int b;
    b = 0;
    while (href_o !== 1'b1 && b < 2000) begin @(negedge clk); b++; end
    check("wait_href_in_budget", (b < 2000), 1);
  endtask

  // Hold enable for n frames, drop it drop_delay cycles into the last one.
  task automatic run_frames(input int n, input int drop_delay);
    @(negedge clk);
    enable = 1'b1;
    wait_busy(1'b1);
    for (int i = 1; i < n; i++) wait_done();
    repeat (drop_delay) @(negedge clk);
    enable = 1'b0;
    wait_done();
    wait_busy(1'b0);
  endtask

  typedef struct {
    int         frames;
    int         drop_delay;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t       tbl[3];
  logic [7:0] total;
  int         d0, r0, n, b;

  initial begin
    tbl[0] = '{frames: 1, drop_delay: 3,   exp_cnt: 8'd1};
    tbl[1] = '{frames: 3, drop_delay: 100, exp_cnt: 8'd4};
    tbl[2] = '{frames: 2, drop_delay: 0,   exp_cnt: 8'd6};
    done_seen = 0; vs_rises = 0; vs_cyc = 0; hr_cyc = 0; d2 = 0; vs_prev = 1'b0;
    rst = 1'b1; enable = 1'b1; rst2 = 1'b1; en2 = 1'b0;

    // reset held with enable high: everything static low
    repeat (10) @(negedge clk);
    check("rst_pclk", pclk_o, 0);
    check("rst_vsync", vsync_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    enable = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // table-driven frame runs
    for (int i = 0; i < 3; i++) begin
      vs_cyc = 0; hr_cyc = 0; d0 = done_seen;
      run_frames(tbl[i].frames, tbl[i].drop_delay);
      check("tbl_frame_cnt", frame_cnt_o, tbl[i].exp_cnt);
      check("tbl_done_pulses", done_seen - d0, tbl[i].frames);
      check("tbl_vsync_cycles", vs_cyc, tbl[i].frames * V_SYNC * TLINE * 2 * PCLK_DIV);
      check("tbl_href_cycles", hr_cyc, tbl[i].frames * V_ACTIVE * H_ACTIVE * BPP * 2 * PCLK_DIV);
      repeat (7) @(negedge clk);
    end
    total = 8'd6;

    // randomized runs
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      n = $urandom_range(1, 2);
      run_frames(n, $urandom_range(0, 200));
      total = total + 8'(n);
      check("rand_frame_cnt", frame_cnt_o, total);
    end

    // enable dropped mid-ACTIVE: frame completes, no further vsync
    d0 = done_seen; r0 = vs_rises;
    @(negedge clk); enable = 1'b1;
    wait_href();
    enable = 1'b0;
    wait_done();
    check("drop_busy_low_at_done", busy_o, 0);
    repeat (200) @(negedge clk);
    check("drop_one_done", done_seen - d0, 1);
    check("drop_one_vsync", vs_rises - r0, 1);
    total = total + 8'd1;
    check("drop_frame_cnt", frame_cnt_o, total);

    // reset pulsed mid-ACTIVE
    @(negedge clk); enable = 1'b1;
    wait_href();
    rst = 1'b1;
    #1;
    check("midrst_href", href_o, 0);
    check("midrst_vsync", vsync_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_cnt", frame_cnt_o, 0);
    enable = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    vs_cyc = 0;
    run_frames(1, 5);
    check("rerun_vsync_cycles", vs_cyc, V_SYNC * TLINE * 2 * PCLK_DIV);
    check("rerun_frame_cnt", frame_cnt_o, 1);

    // 256-frame wrap on the small instance
    @(negedge clk); rst2 = 1'b0; en2 = 1'b1;
    b = 0;
    while (d2 < 255 && b < 8000) begin @(negedge clk); b++; end
    check("wrap_cnt_255", cnt2, 8'hFF);
    while (d2 < 256 && b < 8000) begin @(negedge clk); b++; end
    check("wrap_in_budget", (b < 8000), 1);
    check("wrap_cnt_00", cnt2, 8'h00);
    check("wrap_busy", busy2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
